hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_pkg.sv | 13 +
 rtl/hazard_shadow_stage.sv | 34 +++
 rtl/hazard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding-select
// encodings (common with the ALU operand muxes) and default widths.
package hazard_ctrl_pkg;

    localparam int unsigned DEF_REG_AW = 5;
    localparam int unsigned DEF_CNT_W  = 32;
    localparam int unsigned FWD_W      = 2;

    localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow-pipeline entry {v, rd, wen, ld}; a bubble loads an invalid entry.
module hazard_shadow_stage
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned AW = DEF_REG_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bubble,
    input  logic          d_v,
    input  logic [AW-1:0] d_rd,
    input  logic          d_wen,
    input  logic          d_ld,
    output logic          q_v,
    output logic [AW-1:0] q_rd,
    output logic          q_wen,
    output logic          q_ld
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_v   <= 1'b0;
            q_rd  <= '0;
            q_wen <= 1'b0;
            q_ld  <= 1'b0;
        end else begin
            q_v   <= d_v & ~bubble;
            q_rd  <= d_rd;
            q_wen <= d_wen;
            q_ld  <= d_ld;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stall, redirect flush,
// registered ALU forwarding selects and stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = DEF_REG_AW,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wen,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_if,
    output logic              bubble_ex,
    output logic [FWD_W-1:0]  fwd_rs1_sel,
    output logic [FWD_W-1:0]  fwd_rs2_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              ex_v,   mem_v,   wb_v;
    logic [REG_AW-1:0] ex_rd,  mem_rd,  wb_rd;
    logic              ex_wen, mem_wen, wb_wen;
    logic              ex_ld,  mem_ld,  wb_ld;

    logic              luh;
    logic              ex_m1, ex_m2, mem_m1, mem_m2;
    logic [FWD_W-1:0]  rs1_sel_d, rs2_sel_d;
    logic              wb_unused;

    // x0 is hardwired zero, so it never produces a forwardable value
    function automatic logic entry_match(input logic v, input logic wen,
                                         input logic [REG_AW-1:0] rd,
                                         input logic [REG_AW-1:0] rs);
        return v & wen & (rd != '0) & (rd == rs);
    endfunction

    hazard_shadow_stage #(.AW(REG_AW)) u_s_ex (
        .clk(clk), .rst_n(rst_n), .bubble(bubble_ex),
        .d_v(id_valid), .d_rd(id_rd), .d_wen(id_wen), .d_ld(id_is_load),
        .q_v(ex_v), .q_rd(ex_rd), .q_wen(ex_wen), .q_ld(ex_ld)
    );

    hazard_shadow_stage #(.AW(REG_AW)) u_s_mem (
        .clk(clk), .rst_n(rst_n), .bubble(1'b0),
        .d_v(ex_v), .d_rd(ex_rd), .d_wen(ex_wen), .d_ld(ex_ld),
        .q_v(mem_v), .q_rd(mem_rd), .q_wen(mem_wen), .q_ld(mem_ld)
    );

    hazard_shadow_stage #(.AW(REG_AW)) u_s_wb (
        .clk(clk), .rst_n(rst_n), .bubble(1'b0),
        .d_v(mem_v), .d_rd(mem_rd), .d_wen(mem_wen), .d_ld(mem_ld),
        .q_v(wb_v), .q_rd(wb_rd), .q_wen(wb_wen), .q_ld(wb_ld)
    );

    // WB producers are covered by the regfile write-before-read bypass
    assign wb_unused = ^{wb_v, wb_rd, wb_wen, wb_ld, mem_ld};

    // Hazard detection and stall/flush control; a redirect overrides a stall
    always_comb begin
        ex_m1     = entry_match(ex_v,  ex_wen,  ex_rd,  id_rs1) & id_rs1_used;
        ex_m2     = entry_match(ex_v,  ex_wen,  ex_rd,  id_rs2) & id_rs2_used;
        mem_m1    = entry_match(mem_v, mem_wen, mem_rd, id_rs1) & id_rs1_used;
        mem_m2    = entry_match(mem_v, mem_wen, mem_rd, id_rs2) & id_rs2_used;
        luh       = id_valid & ex_ld & (ex_m1 | ex_m2);
        flush_if  = ex_redirect;
        bubble_ex = ex_redirect | luh;
        stall_if  = luh & ~ex_redirect;
        stall_id  = luh & ~ex_redirect;
    end

    // Forward selection for the instruction entering EX; youngest producer wins
    always_comb begin
        rs1_sel_d = FWD_RF;
        rs2_sel_d = FWD_RF;
        if (id_valid && !bubble_ex) begin
            if (ex_m1)       rs1_sel_d = FWD_EXMEM;
            else if (mem_m1) rs1_sel_d = FWD_MEMWB;
            if (ex_m2)       rs2_sel_d = FWD_EXMEM;
            else if (mem_m2) rs2_sel_d = FWD_MEMWB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_rs1_sel <= FWD_RF;
            fwd_rs2_sel <= FWD_RF;
        end else begin
            fwd_rs1_sel <= rs1_sel_d;
            fwd_rs2_sel <= rs2_sel_d;
        end
    end

    // Performance counters wrap freely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_id)    stall_cnt <= stall_cnt + CNT_W'(1);
            if (ex_redirect) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with a scoreboard queue and a
// negedge monitor that pops and compares one expected record per cycle.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_wen, id_is_load;
    logic        ex_redirect;
    logic        stall_if, stall_id, flush_if, bubble_ex;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
    logic [31:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect),
        .stall_if(stall_if), .stall_id(stall_id), .flush_if(flush_if),
        .bubble_ex(bubble_ex),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          row;
        logic        rst;
        logic        v;
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic [4:0]  rd;
        logic        wen, ld, redir;
        logic        e_stall, e_flush, e_bubble;
        logic [1:0]  e_s1, e_s2;
        logic [31:0] e_sc, e_fc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    function automatic vec_t mk(logic rst, logic v, int rs1, int rs2, logic u1, logic u2,
                                int rd, logic wen, logic ld, logic redir,
                                logic es, logic ef, logic eb, int s1, int s2, int sc, int fc);
        vec_t t;
        t.row = 0; t.rst = rst; t.v = v;
        t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.u1 = u1; t.u2 = u2;
        t.rd = 5'(rd); t.wen = wen; t.ld = ld; t.redir = redir;
        t.e_stall = es; t.e_flush = ef; t.e_bubble = eb;
        t.e_s1 = 2'(s1); t.e_s2 = 2'(s2); t.e_sc = 32'(sc); t.e_fc = 32'(fc);
        return t;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, exp);
        end
    endtask

    // Monitor: one expected record is due at every negedge after it is issued
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("stall_if",    e.row, 32'(stall_if),    32'(e.e_stall));
                chk("stall_id",    e.row, 32'(stall_id),    32'(e.e_stall));
                chk("flush_if",    e.row, 32'(flush_if),    32'(e.e_flush));
                chk("bubble_ex",   e.row, 32'(bubble_ex),   32'(e.e_bubble));
                chk("fwd_rs1_sel", e.row, 32'(fwd_rs1_sel), 32'(e.e_s1));
                chk("fwd_rs2_sel", e.row, 32'(fwd_rs2_sel), 32'(e.e_s2));
                chk("stall_cnt",   e.row, stall_cnt,        e.e_sc);
                chk("flush_cnt",   e.row, flush_cnt,        e.e_fc);
            end
        end
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: got timeout, expected completion");
            $fatal(1, "watchdog expired");
        end
    end

    initial begin
        vec_t t;
        // rst v rs1 rs2 u1 u2 rd wen ld redir | stall flush bubble s1 s2 sc fc
        vecs.push_back(mk(0,1, 1, 2,1,1, 5,1,0,0, 0,0,0, 0,0, 0,0)); // 0 add x5
        vecs.push_back(mk(0,1, 5, 1,1,1, 6,1,0,0, 0,0,0, 0,0, 0,0)); // 1 sub x6,x5,x1
        vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0, 1,0, 0,0)); // 2 sub in EX: 01/00
        vecs.push_back(mk(0,1, 2, 0,1,0, 7,1,1,0, 0,0,0, 0,0, 0,0)); // 3 lw x7
        vecs.push_back(mk(0,1, 7, 7,1,1, 8,1,0,0, 1,0,1, 0,0, 0,0)); // 4 add x8,x7,x7 stalls
        vecs.push_back(mk(0,1, 7, 7,1,1, 8,1,0,0, 0,0,0, 0,0, 1,0)); // 5 held, bubble in EX
        vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0, 2,2, 1,0)); // 6 add in EX: 10/10
        vecs.push_back(mk(0,1, 1, 2,1,1, 0,1,0,0, 0,0,0, 0,0, 1,0)); // 7 add x0
        vecs.push_back(mk(0,1, 0, 0,1,1, 9,1,0,0, 0,0,0, 0,0, 1,0)); // 8 use x0
        vecs.push_back(mk(0,1, 3, 0,1,0, 0,1,1,0, 0,0,0, 0,0, 1,0)); // 9 lw x0
        vecs.push_back(mk(0,1, 0, 0,1,1,10,1,0,0, 0,0,0, 0,0, 1,0)); // 10 use x0, no stall
        vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0, 0,0, 1,0)); // 11
        vecs.push_back(mk(0,1, 1, 0,1,0,11,1,1,0, 0,0,0, 0,0, 1,0)); // 12 lw x11
        vecs.push_back(mk(0,1,11, 2,1,1,12,1,0,1, 0,1,1, 0,0, 1,0)); // 13 consumer + redirect
        vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0, 0,0, 1,1)); // 14
        vecs.push_back(mk(0,1, 1, 2,1,1,13,1,0,0, 0,0,0, 0,0, 1,1)); // 15 add x13
        vecs.push_back(mk(0,1, 4, 0,1,0,13,1,0,0, 0,0,0, 0,0, 1,1)); // 16 addi x13
        vecs.push_back(mk(0,1,13,13,1,1,14,1,0,0, 0,0,0, 0,0, 1,1)); // 17 read x13
        vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0, 1,1, 1,1)); // 18 youngest wins: 01
        vecs.push_back(mk(0,1, 1, 0,1,0,15,1,1,0, 0,0,0, 0,0, 1,1)); // 19 lw x15
        vecs.push_back(mk(0,1, 1,15,1,0,16,1,0,0, 0,0,0, 0,0, 1,1)); // 20 rs2 match unused
        vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0, 0,0, 1,1)); // 21
        vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,1, 0,1,1, 0,0, 1,1)); // 22 bare redirect
        vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0, 0,0, 1,2)); // 23
        vecs.push_back(mk(0,1, 1, 0,1,0, 5,1,1,0, 0,0,0, 0,0, 1,2)); // 24 lw x5
        vecs.push_back(mk(1,1, 5, 5,1,1,17,1,0,0, 0,0,0, 0,0, 0,0)); // 25 reset mid-hazard
        vecs.push_back(mk(0,1, 5, 5,1,1,16,1,0,0, 0,0,0, 0,0, 0,0)); // 26 first after reset
        vecs.push_back(mk(0,0, 0, 0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0)); // 27 its sels: 00/00

        rst_n = 1'b0;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_rd = '0; id_wen = 1'b0; id_is_load = 1'b0; ex_redirect = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            t = vecs[i];
            t.row = i;
            rst_n       = 1'b1;
            id_valid    = t.v;
            id_rs1      = t.rs1;
            id_rs2      = t.rs2;
            id_rs1_used = t.u1;
            id_rs2_used = t.u2;
            id_rd       = t.rd;
            id_wen      = t.wen;
            id_is_load  = t.ld;
            ex_redirect = t.redir;
            if (t.rst) rst_n = 1'b0;
            sb.push_back(t);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", -1, 32'(sb.size()), 32'd0);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
